// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter that funnels NB_MASTER request ports onto one shared memory slave.
// It allows one outstanding transaction, and it sends an error response for an unmapped address or for a slave timeout.
module mem_req_arbiter #(
  parameter int unsigned           NB_MASTER  = 3,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = ADDR_WIDTH'(32'h0010_0000),
  parameter logic [ADDR_WIDTH-1:0] END_ADDR   = ADDR_WIDTH'(32'h001F_FFFF),
  parameter int unsigned           TIMEOUT    = 255
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NB_MASTER-1:0]              m_req_i,
  input  logic [NB_MASTER*ADDR_WIDTH-1:0]   m_addr_i,
  input  logic [NB_MASTER*DATA_WIDTH-1:0]   m_wdata_i,
  input  logic [NB_MASTER-1:0]              m_we_i,
  input  logic [NB_MASTER*DATA_WIDTH/8-1:0] m_be_i,
  output logic [NB_MASTER-1:0]              m_gnt_o,
  output logic [NB_MASTER-1:0]              m_rvalid_o,
  output logic [DATA_WIDTH-1:0]             m_rdata_o,
  output logic                              m_err_o,
  output logic                              s_req_o,
  output logic                              s_we_o,
  output logic [ADDR_WIDTH-1:0]             s_addr_o,
  output logic [DATA_WIDTH-1:0]             s_wdata_o,
  output logic [DATA_WIDTH/8-1:0]           s_be_o,
  input  logic                              s_gnt_i,
  input  logic                              s_rvalid_i,
  input  logic [DATA_WIDTH-1:0]             s_rdata_i
);

  localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
  localparam int unsigned OWN_WIDTH = (NB_MASTER > 1) ? $clog2(NB_MASTER) : 1;
  localparam int unsigned CNT_WIDTH = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [OWN_WIDTH-1:0] LAST_RST = OWN_WIDTH'(NB_MASTER - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(TIMEOUT);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [OWN_WIDTH-1:0]  last_q, last_d;
  logic [OWN_WIDTH-1:0]  owner_q, owner_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BE_WIDTH-1:0]   be_q, be_d;
  logic                  we_q, we_d;

  logic                  win_vld;
  logic [OWN_WIDTH-1:0]  win_idx;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic                  win_in_range;
  logic [NB_MASTER-1:0]  win_oh;
  logic [NB_MASTER-1:0]  own_oh;

  // Candidate index 'off' places after base, wrapping modulo NB_MASTER
  function automatic logic [OWN_WIDTH-1:0] rr_idx(input logic [OWN_WIDTH-1:0] base,
                                                  input int unsigned off);
    int unsigned s;
    s = 32'(base) + 32'd1 + off;
    if (s >= NB_MASTER) s = s - NB_MASTER;
    return OWN_WIDTH'(s);
  endfunction

  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int unsigned i = 0; i < NB_MASTER; i++) begin
      if (!win_vld && m_req_i[rr_idx(last_q, i)]) begin
        win_vld = 1'b1;
        win_idx = rr_idx(last_q, i);
      end
    end
  end

  assign win_addr     = m_addr_i[32'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign win_in_range = (win_addr >= START_ADDR) && (win_addr <= END_ADDR);
  assign win_oh       = NB_MASTER'(1) << win_idx;
  assign own_oh       = NB_MASTER'(1) << owner_q;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    we_d       = we_q;
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    m_rdata_o  = '0;
    m_err_o    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          m_gnt_o = win_oh;
          owner_d = win_idx;
          addr_d  = win_addr;
          wdata_d = m_wdata_i[32'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
          be_d    = m_be_i[32'(win_idx)*BE_WIDTH +: BE_WIDTH];
          we_d    = m_we_i[win_idx];
          state_d = win_in_range ? ST_REQ : ST_ERR;
        end
      end
      ST_REQ: begin
        if (s_gnt_i) begin
          cnt_d   = '0;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        // A real response wins over a timeout that expires in the same cycle
        if (s_rvalid_i) begin
          m_rvalid_o = own_oh;
          m_rdata_o  = s_rdata_i;
          last_d     = owner_q;
          state_d    = ST_IDLE;
        end else if (cnt_q == CNT_MAX) begin
          m_rvalid_o = own_oh;
          m_err_o    = 1'b1;
          last_d     = owner_q;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      ST_ERR: begin
        m_rvalid_o = own_oh;
        m_err_o    = 1'b1;
        last_d     = owner_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      last_q  <= LAST_RST;
      owner_q <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
    end
  end

  assign s_req_o   = (state_q == ST_REQ);
  assign s_we_o    = we_q;
  assign s_addr_o  = addr_q;
  assign s_wdata_o = wdata_q;
  assign s_be_o    = be_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter with the default parameters.
// Inputs change on the falling edge, and outputs are sampled 1 time unit later.
module tb_mem_req_arbiter;

  localparam int unsigned NB = 3;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 255;

  logic              clk;
  logic              rst_n;
  logic [NB-1:0]     m_req;
  logic [NB*AW-1:0]  m_addr;
  logic [NB*DW-1:0]  m_wdata;
  logic [NB-1:0]     m_we;
  logic [NB*DW/8-1:0] m_be;
  logic [NB-1:0]     m_gnt;
  logic [NB-1:0]     m_rvalid;
  logic [DW-1:0]     m_rdata;
  logic              m_err;
  logic              s_req;
  logic              s_we;
  logic [AW-1:0]     s_addr;
  logic [DW-1:0]     s_wdata;
  logic [DW/8-1:0]   s_be;
  logic              s_gnt;
  logic              s_rvalid;
  logic [DW-1:0]     s_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  mem_req_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .m_req_i    (m_req),
    .m_addr_i   (m_addr),
    .m_wdata_i  (m_wdata),
    .m_we_i     (m_we),
    .m_be_i     (m_be),
    .m_gnt_o    (m_gnt),
    .m_rvalid_o (m_rvalid),
    .m_rdata_o  (m_rdata),
    .m_err_o    (m_err),
    .s_req_o    (s_req),
    .s_we_o     (s_we),
    .s_addr_o   (s_addr),
    .s_wdata_o  (s_wdata),
    .s_be_o     (s_be),
    .s_gnt_i    (s_gnt),
    .s_rvalid_i (s_rvalid),
    .s_rdata_i  (s_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; m_req = '0; m_addr = '0; m_wdata = '0; m_we = '0; m_be = '0;
    s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({m_gnt, m_rvalid, m_err, s_req, s_we} !== 9'h0) $display("FAIL reset_ctrl: got %h expected 0", {m_gnt, m_rvalid, m_err, s_req, s_we});
    else n_pass++;
    n_checks++;
    if ({m_rdata, s_addr, s_wdata, s_be} !== 100'h0) $display("FAIL reset_data: got %h expected 0", {m_rdata, s_addr, s_wdata, s_be});
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    #1;
    n_checks++;
    if ({m_gnt, m_rvalid, s_req} !== 7'h0) $display("FAIL post_reset_idle: got %h expected 0", {m_gnt, m_rvalid, s_req});
    else n_pass++;
  endtask

  // Three simultaneous requesters, slave answers immediately: order 0,1,2
  task automatic test_round_robin();
    @(negedge clk);
    m_req = 3'b111;
    for (int k = 0; k < 3; k++) begin
      m_addr[k*AW +: AW] = 32'h0010_0000;
      m_wdata[k*DW +: DW] = 32'h1111_0000 + k;
      m_be[k*4 +: 4] = 4'hF;
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (m_gnt !== (3'b001 << k)) $display("FAIL rr_gnt%0d: got %b expected %b", k, m_gnt, 3'b001 << k);
      else n_pass++;
      @(negedge clk); m_req[k] = 1'b0; s_gnt = 1'b1; #1;
      n_checks++;
      if ({s_req, m_gnt, s_addr, s_wdata} !== {1'b1, 3'b000, 32'h0010_0000, 32'h1111_0000 + 32'(k)})
        $display("FAIL rr_sreq%0d: got req=%b gnt=%b addr=%h wdata=%h", k, s_req, m_gnt, s_addr, s_wdata);
      else n_pass++;
      @(negedge clk); s_gnt = 1'b0; s_rvalid = 1'b1; s_rdata = 32'hCAFE_0000 + 32'(k); #1;
      n_checks++;
      if ({m_rvalid, m_gnt, m_err, m_rdata} !== {3'b001 << k, 3'b000, 1'b0, 32'hCAFE_0000 + 32'(k)})
        $display("FAIL rr_resp%0d: got rvalid=%b gnt=%b err=%b rdata=%h", k, m_rvalid, m_gnt, m_err, m_rdata);
      else n_pass++;
      @(negedge clk); s_rvalid = 1'b0; #1;
    end
  endtask

  // Master 1 read, slave stalls three cycles before accepting
  task automatic test_delayed_grant();
    m_req = 3'b010; m_addr[1*AW +: AW] = 32'h0010_0040; m_we = 3'b000; #1;
    n_checks++;
    if (m_gnt !== 3'b010) $display("FAIL dg_gnt: got %b expected 010", m_gnt);
    else n_pass++;
    @(negedge clk); m_req = 3'b000;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if ({s_req, s_we, s_addr} !== {1'b1, 1'b0, 32'h0010_0040}) $display("FAIL dg_hold%0d: got req=%b we=%b addr=%h", c, s_req, s_we, s_addr);
      else n_pass++;
      @(negedge clk);
    end
    s_gnt = 1'b1; #1;
    n_checks++;
    if (s_req !== 1'b1) $display("FAIL dg_req_at_gnt: got %b expected 1", s_req);
    else n_pass++;
    @(negedge clk); s_gnt = 1'b0; s_rvalid = 1'b1; s_rdata = 32'hDEAD_BEEF; #1;
    n_checks++;
    if ({m_rvalid, m_err, m_rdata} !== {3'b010, 1'b0, 32'hDEAD_BEEF}) $display("FAIL dg_resp: got rvalid=%b err=%b rdata=%h", m_rvalid, m_err, m_rdata);
    else n_pass++;
    @(negedge clk); s_rvalid = 1'b0; #1;
  endtask

  // Master 2 write outside the mapped window gets an error without touching the slave
  task automatic test_out_of_range();
    m_req = 3'b100; m_addr[2*AW +: AW] = 32'h1A10_0000; m_we = 3'b100; #1;
    n_checks++;
    if ({m_gnt, s_req} !== {3'b100, 1'b0}) $display("FAIL oor_gnt: got gnt=%b sreq=%b expected 100/0", m_gnt, s_req);
    else n_pass++;
    @(negedge clk); m_req = 3'b000; #1;
    n_checks++;
    if ({m_rvalid, m_err, m_rdata, s_req} !== {3'b100, 1'b1, 32'h0, 1'b0}) $display("FAIL oor_resp: got rvalid=%b err=%b rdata=%h sreq=%b", m_rvalid, m_err, m_rdata, s_req);
    else n_pass++;
    @(negedge clk); #1;
    n_checks++;
    if ({m_rvalid, m_err, s_req} !== 5'b0) $display("FAIL oor_one_cycle: got rvalid=%b err=%b sreq=%b", m_rvalid, m_err, s_req);
    else n_pass++;
    m_we = 3'b000;
  endtask

  // Master 0 requests continuously, master 2 once: master 2 wins the second round
  task automatic test_fairness();
    m_req = 3'b101; m_addr[2*AW +: AW] = 32'h0010_0200; #1;
    n_checks++;
    if (m_gnt !== 3'b001) $display("FAIL fair_round1: got %b expected 001", m_gnt);
    else n_pass++;
    @(negedge clk); s_gnt = 1'b1;
    @(negedge clk); s_gnt = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h0;
    @(negedge clk); s_rvalid = 1'b0; #1;
    n_checks++;
    if (m_gnt !== 3'b100) $display("FAIL fair_round2: got %b expected 100", m_gnt);
    else n_pass++;
    @(negedge clk); m_req = 3'b001; s_gnt = 1'b1; #1;
    n_checks++;
    if ({s_req, s_addr} !== {1'b1, 32'h0010_0200}) $display("FAIL fair_addr: got req=%b addr=%h", s_req, s_addr);
    else n_pass++;
    @(negedge clk); s_gnt = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h2222_2222; #1;
    n_checks++;
    if ({m_rvalid, m_rdata} !== {3'b100, 32'h2222_2222}) $display("FAIL fair_resp: got rvalid=%b rdata=%h", m_rvalid, m_rdata);
    else n_pass++;
    @(negedge clk); s_rvalid = 1'b0; m_req = 3'b000; #1;
  endtask

  // Slave accepts but never answers: error after exactly TO cycles in RESP
  task automatic test_timeout();
    int early;
    early = 0;
    m_req = 3'b001; #1;
    n_checks++;
    if (m_gnt !== 3'b001) $display("FAIL to_gnt: got %b expected 001", m_gnt);
    else n_pass++;
    @(negedge clk); m_req = 3'b000; s_gnt = 1'b1;
    @(negedge clk); s_gnt = 1'b0;
    for (int c = 0; c < TO; c++) begin
      #1;
      if (m_rvalid !== 3'b000) early++;
      @(negedge clk);
    end
    n_checks++;
    if (early !== 0) $display("FAIL to_early: got %0d early responses expected 0", early);
    else n_pass++;
    #1;
    n_checks++;
    if ({m_rvalid, m_err, m_rdata} !== {3'b001, 1'b1, 32'h0}) $display("FAIL to_resp: got rvalid=%b err=%b rdata=%h", m_rvalid, m_err, m_rdata);
    else n_pass++;
    @(negedge clk); s_rvalid = 1'b1; s_rdata = 32'h5555_5555; s_gnt = 1'b1; #1;
    n_checks++;
    if ({m_rvalid, m_err, m_rdata, s_req} !== {3'b000, 1'b0, 32'h0, 1'b0}) $display("FAIL to_stray: got rvalid=%b err=%b rdata=%h sreq=%b", m_rvalid, m_err, m_rdata, s_req);
    else n_pass++;
    @(negedge clk); s_rvalid = 1'b0; s_gnt = 1'b0; #1;
  endtask

  // Reset while waiting for the response, then a clean transaction from master 0
  task automatic test_reset_mid();
    m_req = 3'b001; #1;
    @(negedge clk); m_req = 3'b000; s_gnt = 1'b1;
    @(negedge clk); s_gnt = 1'b0; rst_n = 1'b0; s_rvalid = 1'b1; s_rdata = 32'hAAAA_AAAA; #1;
    n_checks++;
    if ({m_gnt, m_rvalid, m_err, s_req, m_rdata, s_addr} !== 72'h0)
      $display("FAIL rst_mid: got gnt=%b rvalid=%b err=%b sreq=%b rdata=%h saddr=%h", m_gnt, m_rvalid, m_err, s_req, m_rdata, s_addr);
    else n_pass++;
    @(negedge clk); rst_n = 1'b1; #1;
    n_checks++;
    if ({m_rvalid, s_req} !== 4'b0) $display("FAIL rst_after: got rvalid=%b sreq=%b", m_rvalid, s_req);
    else n_pass++;
    @(negedge clk); s_rvalid = 1'b0; m_req = 3'b001; m_addr[0 +: AW] = 32'h001F_FFFF; #1;
    n_checks++;
    if (m_gnt !== 3'b001) $display("FAIL rst_regnt: got %b expected 001", m_gnt);
    else n_pass++;
    @(negedge clk); m_req = 3'b000; s_gnt = 1'b1; #1;
    n_checks++;
    if ({s_req, s_addr} !== {1'b1, 32'h001F_FFFF}) $display("FAIL rst_sreq: got req=%b addr=%h", s_req, s_addr);
    else n_pass++;
    @(negedge clk); s_gnt = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h0BAD_F00D; #1;
    n_checks++;
    if ({m_rvalid, m_err, m_rdata} !== {3'b001, 1'b0, 32'h0BAD_F00D}) $display("FAIL rst_resp: got rvalid=%b err=%b rdata=%h", m_rvalid, m_err, m_rdata);
    else n_pass++;
    @(negedge clk); s_rvalid = 1'b0; #1;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_delayed_grant();
    test_out_of_range();
    test_fairness();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
